phy_rx_deserializer: RTL and testbench



---
 rtl/phy_rx_deserializer.sv | 158 +++++++++++++++
 tb/tb_phy_rx_deserializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deserializer.sv
// ---------------------------------------------------------------------------
// phy_rx_deserializer
//
// Receive side of a single PHY lane. The lane arrives as one bit per
// clk_32f edge, MSB of each byte first. The block hunts bit by bit for the
// COMMA character and then checks that further COMMAs keep arriving on the
// same 8-bit grid. After LOCK_COUNT consecutive aligned COMMAs the lane is
// declared active. From then on, every byte boundary produces a one-cycle
// byte_strobe. Data bytes are presented on data_out with valid_out set.
// IDLE and COMMA fillers clear valid_out and leave data_out unchanged.
//
// Ports
//   clk_32f     in   bit-rate clock, one serial bit sampled per rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   serial lane bit, MSB of each byte first
//   data_out    out  [7:0] last received data byte
//   valid_out   out  data_out holds a data byte from the last boundary
//   byte_strobe out  one-cycle pulse at each byte boundary while locked
//   active      out  lane locked and aligned (sticky until reset)
// ---------------------------------------------------------------------------
module phy_rx_deserializer #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         LOCK_COUNT = 4      // legal range 1..15
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_CNT4     = LOCK_COUNT[3:0];
    localparam bit         LOCK_ON_FIRST = (LOCK_COUNT == 1);

    logic [7:0] sr_q,        sr_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [1:0] state_q,     state_d;
    logic [7:0] data_q,      data_d;
    logic       valid_q,     valid_d;
    logic       strobe_q,    strobe_d;
    logic       active_q,    active_d;

    // The shift register after this edge's bit is included. Every decision
    // is made on this value, so a byte is judged at the edge sampling bit 0.
    logic [7:0] nxt;
    logic       boundary;
    logic       is_comma;
    logic       is_idle;
    logic [3:0] comma_inc;

    always_comb begin
        nxt       = {sr_q[6:0], data_in};
        boundary  = (bit_cnt_q == 3'd7);
        is_comma  = (nxt == COMMA);
        is_idle   = (nxt == IDLE);
        // Saturating increment so a long COMMA run can never wrap the count.
        comma_inc = (comma_cnt_q == 4'hF) ? 4'hF : comma_cnt_q + 4'd1;

        sr_d        = nxt;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        active_d    = active_q;

        case (state_q)
            ST_SEARCH: begin
                // Bit-wise hunt: any position may start a candidate grid.
                bit_cnt_d = 3'd0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    if (LOCK_ON_FIRST) begin
                        state_d  = ST_LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end

            ST_COUNT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc == LOCK_CNT4) begin
                            state_d  = ST_LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Grid was wrong (or a false match). Restart the hunt
                        // from the next edge; this edge is not re-tested.
                        state_d     = ST_SEARCH;
                        comma_cnt_d = 4'd0;
                        bit_cnt_d   = 3'd0;
                    end
                end
            end

            ST_LOCKED: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_comma || is_idle) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = nxt;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_SEARCH;
                bit_cnt_d   = 3'd0;
                comma_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            state_q     <= ST_SEARCH;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_deserializer
//
// Directed bench for phy_rx_deserializer. Bytes are shifted in MSB first.
// Whenever a byte is sent while the lane should be locked, the expected
// {valid_out, data_out} is pushed to a scoreboard queue. It is popped and
// compared when the DUT raises byte_strobe. Strobe and active timing are
// checked after every edge.
// ---------------------------------------------------------------------------
module tb_phy_rx_deserializer;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    logic [7:0] last_data = 8'h00;

    phy_rx_deserializer dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset for n edges with random serial data; all outputs must be cleared.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f); #1;
            chk("rst_data_out", {24'h0, data_out}, 32'h00);
            chk("rst_valid", {31'h0, valid_out}, 32'h0);
            chk("rst_strobe", {31'h0, byte_strobe}, 32'h0);
            chk("rst_active", {31'h0, active}, 32'h0);
        end
        reset = 1'b0;
        sb.delete();
        last_data = 8'h00;
        $display("reset held %0d edges", n);
    endtask

    // A single unaligned bit while unlocked: no strobe, not active.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f); #1;
        chk("bit_strobe", {31'h0, byte_strobe}, 32'h0);
        chk("bit_active", {31'h0, active}, 32'h0);
    endtask

    // Shift one byte MSB first.
    //   exp_strobe : a boundary strobe is expected on the last bit
    //   act_mid    : expected active during bits 7..1
    //   act_end    : expected active after the last bit
    task automatic send_byte(input logic [7:0] b, input logic exp_strobe,
                             input logic act_mid, input logic act_end);
        logic [8:0] e;
        if (exp_strobe) begin
            if (b == COMMA || b == IDLE) begin
                sb.push_back({1'b0, last_data});
            end else begin
                sb.push_back({1'b1, b});
                last_data = b;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            @(posedge clk_32f); #1;
            if (i > 0) begin
                chk("mid_strobe", {31'h0, byte_strobe}, 32'h0);
                chk("mid_active", {31'h0, active}, {31'h0, act_mid});
            end else begin
                chk("end_strobe", {31'h0, byte_strobe}, {31'h0, exp_strobe});
                chk("end_active", {31'h0, active}, {31'h0, act_end});
            end
            if (byte_strobe === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_strobe", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data_out", {24'h0, data_out}, {24'h0, e[7:0]});
                    chk("sb_valid_out", {31'h0, valid_out}, {31'h0, e[8]});
                end
            end
        end
        $display("byte %02h strobe=%0b valid=%0b data_out=%02h active=%0b",
                 b, byte_strobe, valid_out, data_out, active);
    endtask

    initial begin
        // 1. reset with random data
        do_reset(2);

        // 2. misaligning prefix, then 4 COMMAs; lock on last bit of 4th
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b1);

        // 3. data bytes
        send_byte(8'hFF, 1'b1, 1'b1, 1'b1);
        send_byte(8'hEE, 1'b1, 1'b1, 1'b1);

        // 4. fillers: strobes, valid drops, data_out holds EE
        send_byte(IDLE,  1'b1, 1'b1, 1'b1);
        send_byte(COMMA, 1'b1, 1'b1, 1'b1);
        chk("hold_data_out", {24'h0, data_out}, 32'hEE);

        // 5. from unlocked: 2 COMMAs broken by 0x12, then 4 COMMAs
        do_reset(1);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b1, 1'b1);

        // 6. reset pulse mid-byte while locked, then relock
        data_in = 1'b0; @(posedge clk_32f); #1;
        data_in = 1'b1; @(posedge clk_32f); #1;
        data_in = 1'b0; @(posedge clk_32f); #1;
        chk("pre_rst_active", {31'h0, active}, 32'h1);
        do_reset(1);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b0);
        send_byte(COMMA, 1'b0, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b1);

        chk("sb_drained", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
